vtage_update_queue: RTL and testbench

Training-side front end for the VTAGE value predictor banks. Buffers commit-time validation results in a P_DEPTH-entry FIFO and turns each into one or two write commands for the bank array:
- confidence update of the provider entry;
- allocation of a new entry on a miss or mispredict.

It sits directly upstream of the banks' write port and applies backpressure to the commit stage.

---
 rtl/vtage_update_queue.sv | 187 ++++++++++++++++++
 tb/tb_vtage_update_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vtage_update_queue.sv
// vtage_update_queue: training-side front end for the VTAGE value predictor banks.
// Buffers commit-time validation results in a P_DEPTH-entry FIFO and expands each entry into
// one write (confidence update, or allocation on a miss) or two writes (update of the provider
// followed by allocation in the next longer-history bank on a mispredict).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   upd_*                 validation request (valid/ready handshake from commit)
//   flush_i               drop all queued and in-flight work
//   wr_*                  write command to the bank array (valid/ready handshake)
//   count_o               occupied FIFO entries
//
// Optional feature: define VTAGE_UPDQ_BYPASS_EN to let a single-write request reach wr_* in the
// same cycle when the queue is empty.
module vtage_update_queue #(
  parameter int unsigned P_DEPTH     = 4,
  parameter int unsigned P_NUM_BANKS = 4,
  parameter int unsigned P_IDX_W     = 7,
  parameter int unsigned P_TAG_W     = 9,
  parameter int unsigned P_VAL_W     = 64,
  parameter int unsigned P_CONF_W    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           upd_valid_i,
  output logic                           upd_ready_o,
  input  logic                           upd_hit_i,
  input  logic [$clog2(P_NUM_BANKS)-1:0] upd_provider_i,
  input  logic [P_IDX_W-1:0]             upd_idx_i,
  input  logic [P_TAG_W-1:0]             upd_tag_i,
  input  logic [P_VAL_W-1:0]             upd_value_i,
  input  logic                           upd_correct_i,
  input  logic [P_CONF_W-1:0]            upd_conf_i,
  input  logic                           flush_i,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [$clog2(P_NUM_BANKS)-1:0] wr_bank_o,
  output logic [P_IDX_W-1:0]             wr_idx_o,
  output logic [P_TAG_W-1:0]             wr_tag_o,
  output logic [P_VAL_W-1:0]             wr_value_o,
  output logic [P_CONF_W-1:0]            wr_conf_o,
  output logic                           wr_alloc_o,
  output logic [$clog2(P_DEPTH):0]       count_o
);

  localparam int unsigned BankW = $clog2(P_NUM_BANKS);
  localparam int unsigned PtrW  = $clog2(P_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BankW-1:0] LastBank = BankW'(P_NUM_BANKS - 1);

  typedef enum logic [0:0] {StUpd, StAlloc} state_e;

  // FIFO storage; not reset, contents are only observed while count_q != 0
  logic                mem_hit_q     [P_DEPTH];
  logic                mem_correct_q [P_DEPTH];
  logic [BankW-1:0]    mem_prov_q    [P_DEPTH];
  logic [P_IDX_W-1:0]  mem_idx_q     [P_DEPTH];
  logic [P_TAG_W-1:0]  mem_tag_q     [P_DEPTH];
  logic [P_VAL_W-1:0]  mem_value_q   [P_DEPTH];
  logic [P_CONF_W-1:0] mem_conf_q    [P_DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;

  logic head_valid, head_two, push, pop, hs_head, byp_sel;

  // Selected write source: FIFO head, or the incoming request when bypassing
  logic                s_valid, s_hit, s_correct;
  logic [BankW-1:0]    s_prov;
  logic [P_IDX_W-1:0]  s_idx;
  logic [P_TAG_W-1:0]  s_tag;
  logic [P_VAL_W-1:0]  s_value;
  logic [P_CONF_W-1:0] s_conf;

  assign head_valid  = (count_q != '0);
  assign head_two    = mem_hit_q[rptr_q] & ~mem_correct_q[rptr_q] &
                       (mem_prov_q[rptr_q] != LastBank);
  assign upd_ready_o = (count_q < CntW'(P_DEPTH)) & ~flush_i;
  assign count_o     = count_q;

  always_comb begin
    byp_sel   = 1'b0;
    s_valid   = head_valid;
    s_hit     = mem_hit_q[rptr_q];
    s_correct = mem_correct_q[rptr_q];
    s_prov    = mem_prov_q[rptr_q];
    s_idx     = mem_idx_q[rptr_q];
    s_tag     = mem_tag_q[rptr_q];
    s_value   = mem_value_q[rptr_q];
    s_conf    = mem_conf_q[rptr_q];
`ifdef VTAGE_UPDQ_BYPASS_EN
    // Only single-write requests may skip the FIFO; blocked during flush since no push occurs
    if (!head_valid && (state_q == StUpd) && !flush_i &&
        !(upd_hit_i && !upd_correct_i && (upd_provider_i != LastBank))) begin
      byp_sel   = 1'b1;
      s_valid   = upd_valid_i;
      s_hit     = upd_hit_i;
      s_correct = upd_correct_i;
      s_prov    = upd_provider_i;
      s_idx     = upd_idx_i;
      s_tag     = upd_tag_i;
      s_value   = upd_value_i;
      s_conf    = upd_conf_i;
    end
`endif
  end

  // Write decode; payload is forced to zero when nothing is offered
  always_comb begin
    wr_valid_o = s_valid;
    wr_bank_o  = '0;
    wr_idx_o   = '0;
    wr_tag_o   = '0;
    wr_value_o = '0;
    wr_conf_o  = '0;
    wr_alloc_o = 1'b0;
    if (s_valid) begin
      wr_idx_o   = s_idx;
      wr_tag_o   = s_tag;
      wr_value_o = s_value;
      if (state_q == StAlloc) begin
        wr_bank_o  = s_prov + BankW'(1);
        wr_alloc_o = 1'b1;
      end else if (!s_hit) begin
        wr_alloc_o = 1'b1;
      end else begin
        wr_bank_o = s_prov;
        if (s_correct) begin
          wr_conf_o = (s_conf == '1) ? s_conf : s_conf + P_CONF_W'(1);
        end
      end
    end
  end

  assign hs_head = head_valid & wr_ready_i;
  assign pop     = hs_head & ((state_q == StAlloc) | ~head_two);
  // A bypassed request that is taken immediately never enters the FIFO
  assign push    = upd_valid_i & upd_ready_o & ~(byp_sel & wr_ready_i);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    state_d = state_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      state_d = StUpd;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (hs_head) begin
        state_d = ((state_q == StUpd) && head_two) ? StAlloc : StUpd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= StUpd;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_hit_q[wptr_q]     <= upd_hit_i;
      mem_correct_q[wptr_q] <= upd_correct_i;
      mem_prov_q[wptr_q]    <= upd_provider_i;
      mem_idx_q[wptr_q]     <= upd_idx_i;
      mem_tag_q[wptr_q]     <= upd_tag_i;
      mem_value_q[wptr_q]   <= upd_value_i;
      mem_conf_q[wptr_q]    <= upd_conf_i;
    end
  end

endmodule

// File: tb/tb_vtage_update_queue.sv
// Self-checking bench for vtage_update_queue (default parameters). Expected bank writes are
// pushed to a scoreboard when a request is driven; a negedge monitor compares every offered
// write against the scoreboard head (popping on handshake, checking hold while stalled).
module tb_vtage_update_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid_i, upd_ready_o, upd_hit_i, upd_correct_i, flush_i;
  logic [1:0]  upd_provider_i;
  logic [6:0]  upd_idx_i;
  logic [8:0]  upd_tag_i;
  logic [63:0] upd_value_i;
  logic [2:0]  upd_conf_i;
  logic        wr_valid_o, wr_ready_i, wr_alloc_o;
  logic [1:0]  wr_bank_o;
  logic [6:0]  wr_idx_o;
  logic [8:0]  wr_tag_o;
  logic [63:0] wr_value_o;
  logic [2:0]  wr_conf_o;
  logic [2:0]  count_o;

  int compared = 0;
  int mismatched = 0;

`ifdef VTAGE_UPDQ_BYPASS_EN
  localparam logic       LatValid = 1'b1;
  localparam logic [2:0] Cnt1     = 3'd0;
`else
  localparam logic       LatValid = 1'b0;
  localparam logic [2:0] Cnt1     = 3'd1;
`endif

  typedef struct packed {
    logic [1:0]  bank;
    logic        alloc;
    logic [6:0]  idx;
    logic [8:0]  tag;
    logic [63:0] val;
    logic [2:0]  conf;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  vtage_update_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .upd_valid_i    (upd_valid_i),
    .upd_ready_o    (upd_ready_o),
    .upd_hit_i      (upd_hit_i),
    .upd_provider_i (upd_provider_i),
    .upd_idx_i      (upd_idx_i),
    .upd_tag_i      (upd_tag_i),
    .upd_value_i    (upd_value_i),
    .upd_correct_i  (upd_correct_i),
    .upd_conf_i     (upd_conf_i),
    .flush_i        (flush_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_bank_o      (wr_bank_o),
    .wr_idx_o       (wr_idx_o),
    .wr_tag_o       (wr_tag_o),
    .wr_value_o     (wr_value_o),
    .wr_conf_o      (wr_conf_o),
    .wr_alloc_o     (wr_alloc_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expand a request into its expected bank writes
  task automatic model_push(input logic hit, input logic correct, input logic [1:0] prov,
                            input logic [2:0] conf, input logic [6:0] idx,
                            input logic [8:0] tag, input logic [63:0] val);
    wr_t w;
    w.idx = idx;
    w.tag = tag;
    w.val = val;
    if (!hit) begin
      w.bank = 2'd0; w.alloc = 1'b1; w.conf = 3'd0;
      exp_q.push_back(w);
    end else if (correct) begin
      w.bank = prov; w.alloc = 1'b0; w.conf = (conf == 3'd7) ? 3'd7 : conf + 3'd1;
      exp_q.push_back(w);
    end else begin
      w.bank = prov; w.alloc = 1'b0; w.conf = 3'd0;
      exp_q.push_back(w);
      if (prov != 2'd3) begin
        w.bank = prov + 2'd1; w.alloc = 1'b1;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; holds the request for one cycle
  task automatic push(input logic hit, input logic correct, input logic [1:0] prov,
                      input logic [2:0] conf, input logic [6:0] idx, input logic [63:0] val,
                      input logic acc, input logic chk_lat);
    upd_valid_i = 1'b1; upd_hit_i = hit; upd_correct_i = correct; upd_provider_i = prov;
    upd_conf_i = conf; upd_idx_i = idx; upd_tag_i = {2'b10, idx}; upd_value_i = val;
    if (acc) model_push(hit, correct, prov, conf, idx, {2'b10, idx}, val);
    @(negedge clk);
    chk("upd_ready", 64'(upd_ready_o), 64'(acc));
    if (chk_lat) chk("push_cycle_wr_valid", 64'(wr_valid_o), 64'(LatValid));
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || count_o != 3'd0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 40), 64'(1));
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush_i && wr_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("pending_expected", 64'(exp_q.size() != 0), 64'(1));
      end else begin
        mon_e = exp_q[0];
        chk(wr_ready_i ? "wr_bank" : "stall_bank", 64'(wr_bank_o), 64'(mon_e.bank));
        chk(wr_ready_i ? "wr_alloc" : "stall_alloc", 64'(wr_alloc_o), 64'(mon_e.alloc));
        chk(wr_ready_i ? "wr_idx" : "stall_idx", 64'(wr_idx_o), 64'(mon_e.idx));
        chk(wr_ready_i ? "wr_tag" : "stall_tag", 64'(wr_tag_o), 64'(mon_e.tag));
        chk(wr_ready_i ? "wr_value" : "stall_value", wr_value_o, mon_e.val);
        chk(wr_ready_i ? "wr_conf" : "stall_conf", 64'(wr_conf_o), 64'(mon_e.conf));
        if (wr_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; upd_valid_i = 1'b0; upd_hit_i = 1'b0; upd_correct_i = 1'b0;
    upd_provider_i = '0; upd_idx_i = '0; upd_tag_i = '0; upd_value_i = '0; upd_conf_i = '0;
    flush_i = 1'b0; wr_ready_i = 1'b0;
    #2;
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_wr_valid", 64'(wr_valid_o), 64'(0));
    chk("rst_upd_ready", 64'(upd_ready_o), 64'(1));
    chk("rst_wr_value", wr_value_o, 64'(0));
    chk("rst_wr_bank", 64'(wr_bank_o), 64'(0));
    tick();
    rst_n = 1'b1;

    // Single hit & correct
    wr_ready_i = 1'b1;
    tick();
    push(1'b1, 1'b1, 2'd2, 3'd3, 7'h11, 64'hA1, 1'b1, 1'b1);
    @(negedge clk);
    chk("single_cnt", 64'(count_o), 64'(Cnt1));
    @(negedge clk);
    chk("single_cnt_after", 64'(count_o), 64'(0));

    // Saturation
    tick();
    push(1'b1, 1'b1, 2'd1, 3'd7, 7'h12, 64'hA2, 1'b1, 1'b0);
    drain("drain_sat");

    // Mispredict, provider 1: two back-to-back writes
    tick();
    push(1'b1, 1'b0, 2'd1, 3'd2, 7'h13, 64'h55, 1'b1, 1'b0);
    @(negedge clk);
    chk("misp_first_valid", 64'(wr_valid_o), 64'(1));
    chk("misp_first_alloc", 64'(wr_alloc_o), 64'(0));
    @(negedge clk);
    chk("misp_second_valid", 64'(wr_valid_o), 64'(1));
    chk("misp_second_alloc", 64'(wr_alloc_o), 64'(1));
    @(negedge clk);
    chk("misp_done_valid", 64'(wr_valid_o), 64'(0));

    // Mispredict on the last bank: update only
    tick();
    push(1'b1, 1'b0, 2'd3, 3'd4, 7'h14, 64'h66, 1'b1, 1'b0);
    drain("drain_misp_last");

    // Fill under backpressure, then refuse a push while full even with a pop
    wr_ready_i = 1'b0;
    tick();
    push(1'b1, 1'b1, 2'd0, 3'd1, 7'h20, 64'hB0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 2'd2, 3'd5, 7'h21, 64'hB1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'd3, 3'd6, 7'h22, 64'hB2, 1'b1, 1'b0);
    push(1'b1, 1'b1, 2'd3, 3'd5, 7'h23, 64'hB3, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_count", 64'(count_o), 64'(4));
    chk("full_upd_ready", 64'(upd_ready_o), 64'(0));
    repeat (2) @(negedge clk);
    tick();
    wr_ready_i = 1'b1;
    push(1'b1, 1'b1, 2'd1, 3'd0, 7'h24, 64'hB4, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_pop_cnt", 64'(count_o), 64'(3));
    drain("drain_full");

    // Flush with the head entry in its allocation write
    wr_ready_i = 1'b0;
    tick();
    push(1'b1, 1'b0, 2'd1, 3'd3, 7'h30, 64'hC0, 1'b1, 1'b0);
    push(1'b1, 1'b1, 2'd0, 3'd2, 7'h31, 64'hC1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'd0, 3'd0, 7'h32, 64'hC2, 1'b1, 1'b0);
    wr_ready_i = 1'b1;
    @(negedge clk);
    tick();
    wr_ready_i = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", 64'(count_o), 64'(3));
    chk("pre_flush_alloc", 64'(wr_alloc_o), 64'(1));
    tick();
    flush_i = 1'b1;
    upd_valid_i = 1'b1; upd_hit_i = 1'b0; upd_idx_i = 7'h3F;
    exp_q.delete();
    @(negedge clk);
    chk("flush_upd_ready", 64'(upd_ready_o), 64'(0));
    tick();
    flush_i = 1'b0;
    upd_valid_i = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 64'(count_o), 64'(0));
    chk("post_flush_wr_valid", 64'(wr_valid_o), 64'(0));
    wr_ready_i = 1'b1;
    tick();
    push(1'b1, 1'b1, 2'd1, 3'd0, 7'h33, 64'hC3, 1'b1, 1'b0);
    drain("drain_flush");

    // Miss on an empty queue: bypass timing depends on build
    tick();
    push(1'b0, 1'b1, 2'd2, 3'd5, 7'h40, 64'hD0, 1'b1, 1'b1);
    @(negedge clk);
    chk("miss_cnt", 64'(count_o), 64'(Cnt1));
    drain("drain_miss");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
